// File: rtl/phy_rx_sync_ctrl.sv
// -----------------------------------------------------------------------------
// phy_rx_sync_ctrl
//
// Receive-side byte alignment and link-state controller. Watches the retimed
// serial bit stream (MSB first) for COM symbols. It locks byte phase after
// LOCK_COUNT consecutive byte-aligned COMs. In sync it presents each data byte
// for a full 8-cycle byte period, and it drops back to hunting after GAP_MAX
// consecutive data bytes with no COM/IDL.
//
// Ports:
//   clk_32f     - serial bit clock, the only clock
//   rst         - asynchronous active-high reset
//   data_in     - retimed serial bit, MSB first
//   data_out    - last aligned data byte (held for the whole byte period)
//   valid_out   - data_out holds a data byte (not COM, not IDL)
//   byte_strobe - one-cycle pulse at each aligned byte boundary outside HUNT
//   active      - link in sync
//   idle_out    - registered inverse of active, feeds the IDLE return flop
//   state       - 0 = HUNT, 1 = CHECK, 2 = SYNC (debug)
// -----------------------------------------------------------------------------
module phy_rx_sync_ctrl #(
   parameter int unsigned LOCK_COUNT = 4,      // 2..15
   parameter int unsigned GAP_MAX    = 64,     // 2..255
   parameter logic [7:0]  COM        = 8'hBC,
   parameter logic [7:0]  IDL        = 8'h7C
) (
   input  logic       clk_32f,
   input  logic       rst,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active,
   output logic       idle_out,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      CHECK = 2'd1,
      SYNC  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] sr_q;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] com_cnt_q, com_cnt_d, com_inc;
   logic [7:0] gap_q, gap_d, gap_inc;
   logic [7:0] data_d;
   logic       valid_d, strobe_d, active_d, idle_d;
   logic       boundary;

   assign state = state_q;

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q + 3'd1;
      com_cnt_d = com_cnt_q;
      gap_d     = gap_q;
      data_d    = data_out;
      valid_d   = valid_out;
      active_d  = active;
      idle_d    = idle_out;
      com_inc   = com_cnt_q + 4'd1;
      gap_inc   = gap_q + 8'd1;
      boundary  = (state_q != HUNT) && (cnt_q == 3'd0);

      case (state_q)
         HUNT: begin
            // The COM already sits in sr, so the next byte ends 8 edges later:
            // cnt = 1 here puts the following boundary at cnt == 0.
            if (sr_q == COM) begin
               state_d   = CHECK;
               cnt_d     = 3'd1;
               com_cnt_d = 4'd1;
            end
         end

         CHECK: begin
            data_d  = 8'h00;
            valid_d = 1'b0;
            if (boundary) begin
               if (sr_q == COM) begin
                  com_cnt_d = com_inc;
                  if (com_inc == LOCK_COUNT[3:0]) begin
                     state_d  = SYNC;
                     active_d = 1'b1;
                     idle_d   = 1'b0;
                     gap_d    = 8'd0;
                  end
               end else begin
                  state_d   = HUNT;
                  com_cnt_d = 4'd0;
               end
            end
         end

         SYNC: begin
            if (boundary) begin
               if (sr_q == COM || sr_q == IDL) begin
                  valid_d = 1'b0;
                  gap_d   = 8'd0;
               end else if (gap_inc == GAP_MAX[7:0]) begin
                  // Framing lost: the offending byte is dropped, not presented.
                  state_d   = HUNT;
                  active_d  = 1'b0;
                  idle_d    = 1'b1;
                  valid_d   = 1'b0;
                  data_d    = 8'h00;
                  com_cnt_d = 4'd0;
                  gap_d     = 8'd0;
               end else begin
                  data_d  = sr_q;
                  valid_d = 1'b1;
                  gap_d   = gap_inc;
               end
            end
         end

         default: state_d = HUNT;
      endcase

      // Suppressed on the boundary that falls back to HUNT, so the strobe is
      // never seen while state reads HUNT.
      strobe_d = boundary && (state_d != HUNT);
   end

   // State and output registers.
   always_ff @(posedge clk_32f or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         sr_q        <= 8'h00;
         cnt_q       <= 3'd0;
         com_cnt_q   <= 4'd0;
         gap_q       <= 8'd0;
         data_out    <= 8'h00;
         valid_out   <= 1'b0;
         byte_strobe <= 1'b0;
         active      <= 1'b0;
         idle_out    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q     <= state_d;
         sr_q        <= {sr_q[6:0], data_in};
         cnt_q       <= cnt_d;
         com_cnt_q   <= com_cnt_d;
         gap_q       <= gap_d;
         data_out    <= data_d;
         valid_out   <= valid_d;
         byte_strobe <= strobe_d;
         active      <= active_d;
         idle_out    <= idle_d;
      end
   end

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phy_rx_sync_ctrl
//
// Directed bench for phy_rx_sync_ctrl with default parameters. Bits are driven
// on the falling edge and outputs are sampled 1 ns after the rising edge that
// took the bit. A byte boundary evaluates the byte whose last bit arrived on the
// previous edge. After a byte is sent in full, the outputs therefore reflect
// the byte before it, and the first bit of a byte shows the previous byte.
// -----------------------------------------------------------------------------
module tb_phy_rx_sync_ctrl;

   localparam logic [7:0] COM = 8'hBC;
   localparam logic [7:0] IDL = 8'h7C;

   logic       clk_32f = 1'b0;
   logic       rst     = 1'b1;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;
   logic       idle_out;
   logic [1:0] state;

   int n_cmp = 0;
   int n_err = 0;

   phy_rx_sync_ctrl dut (
      .clk_32f     (clk_32f),
      .rst         (rst),
      .data_in     (data_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .active      (active),
      .idle_out    (idle_out),
      .state       (state)
   );

   always #5 clk_32f = ~clk_32f;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk_32f);
      data_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   // Bits 6..0 only, for when bit 7 was sent separately.
   task automatic send_tail(input logic [7:0] b);
      for (int i = 6; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic do_reset;
      rst     = 1'b1;
      data_in = 1'b0;
      repeat (2) @(posedge clk_32f);
      @(negedge clk_32f);
      rst = 1'b0;
   endtask

   // Reset, a short non-COM prefix, four COMs; ends one edge before SYNC.
   task automatic lock_up;
      do_reset;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      repeat (4) send_byte(COM);
   endtask

   initial begin
      logic [7:0] b;

      // ---------------- reset values ----------------
      do_reset;
      check("rst_state", state, 0);
      check("rst_active", active, 0);
      check("rst_idle", idle_out, 1);
      check("rst_data", data_out, 8'h00);
      check("rst_valid", valid_out, 0);
      check("rst_strobe", byte_strobe, 0);

      // ---------------- lock ----------------
      do_reset;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_byte(COM);                       // last COM bit at edge t
      check("lock_hunt_at_t", state, 0);
      send_bit(1'b1);                       // edge t+1: detect
      check("lock_check_at_t1", state, 1);
      send_tail(COM);
      send_byte(COM);
      send_byte(COM);                       // edge t+24
      check("lock_not_yet_active", active, 0);
      check("lock_still_check", state, 1);
      send_bit(1'b0);                       // edge t+25: 4th COM evaluated
      check("lock_active", active, 1);
      check("lock_idle_low", idle_out, 0);
      check("lock_state_sync", state, 2);
      check("lock_strobe", byte_strobe, 1);
      check("lock_valid_com", valid_out, 0);
      check("lock_data_zero", data_out, 8'h00);
      send_tail(8'h11);
      send_bit(1'b0);                       // boundary for 0x11
      check("lock_data_11", data_out, 8'h11);
      check("lock_valid_11", valid_out, 1);
      check("lock_strobe_11", byte_strobe, 1);
      b = 8'h22;
      for (int i = 6; i >= 0; i--) begin
         send_bit(b[i]);
         check("lock_hold_11", data_out, 8'h11);
         check("lock_hold_valid", valid_out, 1);
         check("lock_hold_strobe", byte_strobe, 0);
      end
      send_bit(1'b0);                       // boundary for 0x22
      check("lock_data_22", data_out, 8'h22);
      check("lock_valid_22", valid_out, 1);
      send_tail(IDL);
      send_bit(1'b1);                       // boundary for IDL
      check("lock_idl_valid", valid_out, 0);
      check("lock_idl_data", data_out, 8'h22);

      // ---------------- broken lock ----------------
      do_reset;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      repeat (3) send_byte(COM);
      send_byte(8'h55);
      check("brk_check_before_55", state, 1);
      send_bit(1'b1);                       // 0x55 evaluated, first bit of COM
      check("brk_hunt_after_55", state, 0);
      check("brk_data_after_55", data_out, 8'h00);
      check("brk_valid_after_55", valid_out, 0);
      send_tail(COM);
      check("brk_hunt_com_end", state, 0);
      send_bit(1'b1);
      check("brk_redetect", state, 1);
      send_tail(COM);
      send_byte(COM);
      send_byte(COM);
      check("brk_not_active", active, 0);
      send_bit(1'b0);
      check("brk_active", active, 1);
      send_tail(8'h33);
      send_byte(8'h44);
      check("brk_data_33", data_out, 8'h33);
      check("brk_valid_33", valid_out, 1);

      // ---------------- filler ----------------
      lock_up;
      repeat (40) send_byte(8'hA5);
      check("fill_data_a5", data_out, 8'hA5);
      check("fill_valid_a5", valid_out, 1);
      send_byte(IDL);
      send_byte(8'hA5);                     // outputs show IDL
      check("fill_idl_valid", valid_out, 0);
      check("fill_idl_data", data_out, 8'hA5);
      repeat (39) send_byte(8'hA5);
      check("fill_valid_again", valid_out, 1);
      send_byte(COM);
      send_byte(8'hA5);                     // outputs show COM
      check("fill_com_valid", valid_out, 0);
      check("fill_com_data", data_out, 8'hA5);
      repeat (40) send_byte(8'hA5);
      check("fill_active", active, 1);
      check("fill_state", state, 2);
      check("fill_valid_end", valid_out, 1);

      // ---------------- gap loss ----------------
      lock_up;
      send_byte(8'h01);
      send_byte(8'h02);
      check("gap_data_01", data_out, 8'h01);
      for (int i = 3; i <= 64; i++) send_byte(8'(i));
      check("gap_data_63", data_out, 8'h3F);
      check("gap_valid_63", valid_out, 1);
      check("gap_active_63", active, 1);
      send_bit(1'b0);                       // 64th data byte evaluated
      check("gap_active_lost", active, 0);
      check("gap_idle", idle_out, 1);
      check("gap_data_zero", data_out, 8'h00);
      check("gap_valid_zero", valid_out, 0);
      check("gap_state_hunt", state, 0);

      // ---------------- phase ----------------
      do_reset;
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      repeat (4) send_byte(COM);
      send_byte(8'hD1);
      check("phase_active", active, 1);
      send_byte(8'h2E);
      check("phase_d1", data_out, 8'hD1);
      send_byte(8'h5B);
      check("phase_2e", data_out, 8'h2E);
      send_byte(8'h00);
      check("phase_5b", data_out, 8'h5B);
      check("phase_valid", valid_out, 1);

      // ---------------- asynchronous reset mid-stream ----------------
      lock_up;
      send_byte(8'h11);
      send_byte(8'h22);
      check("ar_pre_data", data_out, 8'h11);
      send_bit(1'b0);
      send_bit(1'b1);
      #2 rst = 1'b1;
      #1;
      check("ar_state", state, 0);
      check("ar_active", active, 0);
      check("ar_idle", idle_out, 1);
      check("ar_data", data_out, 8'h00);
      check("ar_valid", valid_out, 0);
      check("ar_strobe", byte_strobe, 0);
      repeat (3) @(posedge clk_32f);
      #1;
      check("ar_hold_idle", idle_out, 1);
      check("ar_hold_state", state, 0);
      @(negedge clk_32f);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
